// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad scanner: FSM state type,
//   (row,col) -> item code map, column reset pattern and small decode helpers.
//   Optional feature macro used by the scanner: KEYPAD_GHOST_REJECT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Column drive after reset: column 0 active (one-hot-low).
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row[1:0], col[1:0]}; '*' reports as E, '#' as F.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // One-hot-low drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index row that is pulled low (0 when none are).
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // More than one row pulled low on the same sample.
    function automatic logic multi_low(input logic [3:0] r);
        return ($countones(~r) > 1);
    endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// keypad_debounce_cnt
//   Saturating count of consecutive matching dwell-end samples.
//   Ports:
//     clk_i   - clock, rising edge
//     rst_i   - asynchronous active-high reset
//     clr_i   - synchronous clear (wins over enable)
//     en_i    - count one matching sample this cycle
//     term_o  - this enable brings the count to DEB_SCANS, so the caller
//               can act on the same edge the terminal value is reached
module keypad_debounce_cnt #(
    parameter int DEB_SCANS = 4,
    parameter int CNT_W     = $clog2(DEB_SCANS + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_W'(DEB_SCANS))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign term_o = en_i && (cnt_q == CNT_W'(DEB_SCANS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column per SCAN_DIV-cycle dwell,
//   debounces on dwell-end samples and emits a one-cycle KEY_PRESS with the
//   item code of each accepted key.
//   Ports:
//     CLK       - system clock, rising edge
//     RESET     - asynchronous active-high reset
//     ROW[3:0]  - keypad rows, active-low, asynchronous to CLK
//     COL[3:0]  - column drive, one-hot-low
//     ITEM_CODE - code of last accepted key, changes only with KEY_PRESS
//     KEY_PRESS - one-cycle pulse per accepted key
//   Optional feature: define KEYPAD_GHOST_REJECT_EN to treat samples with
//   more than one low row as no-key while scanning/debouncing; otherwise the
//   lowest-index low row wins.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] ITEM_CODE,
    output logic       KEY_PRESS
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [3:0]       row_s1_q, row_s_q;
    logic [DIV_W-1:0] div_q;
    kp_state_e        state_q;
    logic [1:0]       col_idx_q, row_idx_q;
    logic [3:0]       col_q, row_lat_q, item_q;
    logic             press_q;

    logic dwell_end, all_high, key_seen, same, cnt_clr, cnt_en, deb_term;
    logic [1:0] col_nxt;

    // Two-flop synchronizer; idle keypad reads all-high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_s1_q <= 4'hF;
            row_s_q  <= 4'hF;
        end else begin
            row_s1_q <= ROW;
            row_s_q  <= row_s1_q;
        end
    end

    // Free-running dwell timer; keeps running while COL is frozen so that
    // held/release decisions still happen once per dwell.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_q <= '0;
        end else if (dwell_end) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
    assign all_high  = &row_s_q;
`ifdef KEYPAD_GHOST_REJECT_EN
    assign key_seen  = !all_high && !multi_low(row_s_q);
`else
    assign key_seen  = !all_high;
`endif
    assign same      = (row_s_q == row_lat_q);
    assign col_nxt   = col_idx_q + 2'd1;

    // Counter is held clear outside the two counting states, so every entry
    // into DEBOUNCE or RELEASE starts from zero.
    always_comb begin
        cnt_clr = (state_q == ST_SCAN) || (state_q == ST_HELD);
        cnt_en  = 1'b0;
        if (dwell_end) begin
            if (state_q == ST_DEBOUNCE) cnt_en = key_seen && same;
            if (state_q == ST_RELEASE)  cnt_en = all_high;
        end
    end

    keypad_debounce_cnt #(
        .DEB_SCANS (DEB_SCANS)
    ) u_deb (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (deb_term)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            col_q     <= COL_RESET;
            row_idx_q <= 2'd0;
            row_lat_q <= 4'hF;
            item_q    <= 4'h0;
            press_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (dwell_end) begin
                case (state_q)
                    ST_SCAN: begin
                        if (key_seen) begin
                            row_lat_q <= row_s_q;
                            row_idx_q <= low_row(row_s_q);
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            col_idx_q <= col_nxt;
                            col_q     <= col_drive(col_nxt);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (key_seen && same) begin
                            if (deb_term) begin
                                press_q <= 1'b1;
                                item_q  <= KEY_MAP[{row_idx_q, col_idx_q}];
                                state_q <= ST_HELD;
                            end
                        end else begin
                            // Bounce: give up and carry on from the next column.
                            state_q   <= ST_SCAN;
                            col_idx_q <= col_nxt;
                            col_q     <= col_drive(col_nxt);
                        end
                    end
                    ST_HELD: begin
                        if (all_high) state_q <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        if (!all_high) begin
                            state_q <= ST_HELD;
                        end else if (deb_term) begin
                            state_q   <= ST_SCAN;
                            col_idx_q <= col_nxt;
                            col_q     <= col_drive(col_nxt);
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    assign COL       = col_q;
    assign ITEM_CODE = item_q;
    assign KEY_PRESS = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;

    logic       CLK;
    logic       RESET;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] ITEM_CODE;
    logic       KEY_PRESS;

    // Physical key state, index row*4+col.
    logic [15:0] key_dn;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int glitch_cnt = 0;
    int col_bad    = 0;
    logic [3:0] prev_code = 4'h0;
    logic [3:0] got_q[$];
    int         got_cyc[$];

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ROW       (ROW),
        .COL       (COL),
        .ITEM_CODE (ITEM_CODE),
        .KEY_PRESS (KEY_PRESS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Passive matrix: a closed key pulls its row low while its column is driven low.
    function automatic logic [3:0] kp_rows(input logic [3:0] col, input logic [15:0] dn);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (dn[rr*4+cc] && !col[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    assign ROW = kp_rows(COL, key_dn);

    // Printed keypad legend as arithmetic: digits 1-9 fill the top 3x3,
    // right column reads A,B,C,D downwards, bottom row is *,0,#.
    function automatic logic [3:0] ref_code(input int r, input int c);
        if (r < 3 && c < 3) return 4'(r * 3 + c + 1);
        if (c == 3)         return 4'(10 + r);
        if (c == 0)         return 4'hE;
        if (c == 1)         return 4'h0;
        return 4'hF;
    endfunction

    // Pulse recorder plus hold/one-hot observers.
    always @(negedge CLK) begin
        cyc++;
        if (!RESET) begin
            if (KEY_PRESS) begin
                got_q.push_back(ITEM_CODE);
                got_cyc.push_back(cyc);
            end else if (ITEM_CODE !== prev_code) begin
                glitch_cnt++;
            end
            if ($countones(~COL) != 1) col_bad++;
        end
        prev_code = ITEM_CODE;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    // Bounded wait for a given column drive pattern.
    task automatic wait_col(input logic [3:0] pat, input string tag);
        int k;
        k = 0;
        while (COL !== pat && k < 100) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (COL !== pat) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for COL=%b, got %b", tag, pat, COL);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        wait_cycles(3);
        n_checks++; if (COL !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", COL); end
        n_checks++; if (ITEM_CODE !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", ITEM_CODE); end
        n_checks++; if (KEY_PRESS !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b want 0", KEY_PRESS); end
        RESET = 1'b0;
        // Column advances after exactly SCAN_DIV cycles, wrapping after four dwells.
        repeat (SCAN_DIV - 1) @(posedge CLK);
        #1;
        n_checks++; if (COL !== 4'b1110) begin n_fail++; $display("FAIL dwell_hold: got %b want 1110", COL); end
        @(posedge CLK); #1;
        n_checks++; if (COL !== 4'b1101) begin n_fail++; $display("FAIL dwell_step: got %b want 1101", COL); end
        repeat (3 * SCAN_DIV) @(posedge CLK);
        #1;
        n_checks++; if (COL !== 4'b1110) begin n_fail++; $display("FAIL dwell_wrap: got %b want 1110", COL); end
    endtask

    task automatic test_bounce();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            key_dn[2*4+2] = 1'b1;
            wait_cycles(6);
            key_dn[2*4+2] = 1'b0;
            wait_cycles(6);
        end
        wait_cycles(60);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 0", got_q.size()); end
        n_checks++; if (ITEM_CODE !== 4'h0) begin n_fail++; $display("FAIL bounce_code: got %h want 0", ITEM_CODE); end
    endtask

    task automatic test_key5();
        clear_log();
        key_dn[1*4+1] = 1'b1;
        wait_cycles(200);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL key5_pulses: got %0d want 1", got_q.size()); end
        n_checks++; if (ITEM_CODE !== ref_code(1, 1)) begin n_fail++; $display("FAIL key5_code: got %h want %h", ITEM_CODE, ref_code(1, 1)); end
        n_checks++; if (COL !== 4'b1101) begin n_fail++; $display("FAIL key5_col_frozen: got %b want 1101", COL); end
        key_dn[1*4+1] = 1'b0;
        wait_cycles(60);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL key5_after_release: got %0d want 1", got_q.size()); end
        n_checks++; if (ITEM_CODE !== 4'h5) begin n_fail++; $display("FAIL key5_code_held: got %h want 5", ITEM_CODE); end
    endtask

    task automatic test_sequence();
        int r [3] = '{0, 0, 3};
        int c [3] = '{0, 1, 0};
        logic [3:0] want [3] = '{4'h1, 4'h2, 4'hE};
        clear_log();
        for (int i = 0; i < 3; i++) begin
            key_dn[r[i]*4+c[i]] = 1'b1;
            wait_cycles(80);
            key_dn[r[i]*4+c[i]] = 1'b0;
            wait_cycles(60);
        end
        n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL seq_pulses: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== want[i] || want[i] !== ref_code(r[i], c[i])) begin
                    n_fail++; $display("FAIL seq_code%0d: got %h want %h", i, got_q[i], ref_code(r[i], c[i]));
                end
            end
        end
    endtask

    task automatic test_reset_debounce();
        int rel;
        clear_log();
        wait_col(4'b1101, "rst_sync_col1");
        key_dn[0*4+2] = 1'b1;
        wait_col(4'b1011, "rst_reach_col2");
        // Debounce is entered at the end of this column-2 dwell; reset 3 cycles later.
        repeat (SCAN_DIV + 3) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        n_checks++; if (COL !== 4'b1110) begin n_fail++; $display("FAIL rstdeb_col: got %b want 1110", COL); end
        n_checks++; if (ITEM_CODE !== 4'h0) begin n_fail++; $display("FAIL rstdeb_code: got %h want 0", ITEM_CODE); end
        n_checks++; if (KEY_PRESS !== 1'b0) begin n_fail++; $display("FAIL rstdeb_press: got %b want 0", KEY_PRESS); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstdeb_early_pulse: got %0d want 0", got_q.size()); end
        wait_cycles(3);
        RESET = 1'b0;
        rel = cyc;
        wait_cycles(60);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstdeb_pulses: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== ref_code(0, 2)) begin n_fail++; $display("FAIL rstdeb_code_after: got %h want %h", got_q[0], ref_code(0, 2)); end
            // Column 2 is reached after two dwells, then DEB_SCANS more dwells are needed.
            n_checks++;
            if (got_cyc[0] - rel < (2 + DEB_SCANS) * SCAN_DIV) begin
                n_fail++; $display("FAIL rstdeb_latency: got %0d want >= %0d", got_cyc[0] - rel, (2 + DEB_SCANS) * SCAN_DIV);
            end
        end
        key_dn[0*4+2] = 1'b0;
        wait_cycles(60);
    endtask

    task automatic test_ghost();
        int         want_n;
        logic [3:0] want_code;
`ifdef KEYPAD_GHOST_REJECT_EN
        want_n    = 0;
        want_code = ITEM_CODE;
`else
        want_n    = 1;
        want_code = ref_code(0, 0);
`endif
        clear_log();
        wait_col(4'b1101, "ghost_sync_col1");
        key_dn[0*4+0] = 1'b1;
        key_dn[1*4+0] = 1'b1;
        wait_cycles(120);
        key_dn[0*4+0] = 1'b0;
        key_dn[1*4+0] = 1'b0;
        wait_cycles(60);
        n_checks++; if (got_q.size() != want_n) begin n_fail++; $display("FAIL ghost_pulses: got %0d want %0d", got_q.size(), want_n); end
        n_checks++; if (ITEM_CODE !== want_code) begin n_fail++; $display("FAIL ghost_code: got %h want %h", ITEM_CODE, want_code); end
    endtask

    task automatic test_random();
        logic [3:0] exp_q[$];
        int r, c;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            exp_q.push_back(ref_code(r, c));
            key_dn[r*4+c] = 1'b1;
            wait_cycles(int'($urandom_range(80, 150)));
            key_dn[r*4+c] = 1'b0;
            wait_cycles(int'($urandom_range(50, 100)));
        end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_pulses: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_code%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++; if (glitch_cnt != 0) begin n_fail++; $display("FAIL code_hold: %0d changes without pulse, want 0", glitch_cnt); end
        n_checks++; if (col_bad != 0) begin n_fail++; $display("FAIL col_onehot: %0d bad cycles, want 0", col_bad); end
    endtask

    initial begin
        RESET  = 1'b1;
        key_dn = '0;
        test_reset();
        test_bounce();
        test_key5();
        test_sequence();
        test_reset_debounce();
        test_ghost();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
